// File: rtl/div_seq_32_pkg.sv
// Shared definitions for the sequential signed divider: FSM encodings and width defaults.
package div_seq_32_pkg;

    localparam int DIV_WIDTH = 32;

    // Most negative two's-complement value at the default width.
    localparam logic [DIV_WIDTH-1:0] DIV_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_seq_32_if.sv
// Start/ready handshake and operand/result bus of the sequential divider.
interface div_seq_32_if
    import div_seq_32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             ctrl_div;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_quotient;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    // Issuer side (multdiv control)
    modport master (
        output ctrl_div, data_operandA, data_operandB,
        input  data_quotient, data_remainder, data_exception, data_resultRDY, busy
    );

    // Divider side
    modport slave (
        input  ctrl_div, data_operandA, data_operandB,
        output data_quotient, data_remainder, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/div_seq_32_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the
// divisor magnitude with a two-block carry-select subtractor, keep or restore.
module div_seq_32_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH:0]   divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_bit_o
);
    localparam int N = WIDTH + 1;
    localparam int L = N / 2;
    localparam int H = N - L;

    logic [N-1:0] shifted;
    logic [N-1:0] divisor_n;
    logic [N-1:0] diff;
    logic [L:0]   lo_sum;
    logic [H:0]   hi_sum0;
    logic [H:0]   hi_sum1;
    logic         carry_out;

    assign shifted   = {rem_i, dvd_bit_i};
    assign divisor_n = ~divisor_i;

    // Low block computes a + ~b + 1; the high block is precomputed for both carries.
    assign lo_sum  = {1'b0, shifted[L-1:0]} + {1'b0, divisor_n[L-1:0]} + {{L{1'b0}}, 1'b1};
    assign hi_sum0 = {1'b0, shifted[N-1:L]} + {1'b0, divisor_n[N-1:L]};
    assign hi_sum1 = hi_sum0 + {{H{1'b0}}, 1'b1};

    assign diff      = {(lo_sum[L] ? hi_sum1[H-1:0] : hi_sum0[H-1:0]), lo_sum[L-1:0]};
    assign carry_out = lo_sum[L] ? hi_sum1[H] : hi_sum0[H];

    // Carry out means no borrow: the shifted remainder is >= divisor, keep the difference.
    assign q_bit_o = carry_out;
    assign rem_o   = carry_out ? diff : shifted;

endmodule

// File: rtl/div_seq_32.sv
// Sequential signed restoring divider: one quotient bit per clock, results in flops,
// start/ready handshake through div_seq_32_if.
module div_seq_32
    import div_seq_32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    div_seq_32_if.slave  div_if
);
    localparam int               CW      = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH:0]    absb_q, absb_d;
    logic [WIDTH:0]    rem_q, rem_d;
    logic [WIDTH-1:0]  dvd_q, dvd_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              exc_pend_q, exc_pend_d;
    logic [WIDTH-1:0]  quotient_q, quotient_d;
    logic [WIDTH-1:0]  remainder_q, remainder_d;
    logic              exception_q, exception_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              b_zero;
    logic              overflow;
    logic [WIDTH-1:0]  abs_a;
    logic [WIDTH-1:0]  abs_b;
    logic [WIDTH:0]    step_rem;
    logic              step_q;

    // A start is taken only in IDLE once the previous result cycle has closed.
    assign accept   = (state_q == DIV_IDLE) && !busy_q && div_if.ctrl_div;
    assign b_zero   = (div_if.data_operandB == '0);
    assign overflow = (div_if.data_operandA == MIN_VAL) && (div_if.data_operandB == '1);
    // -MIN wraps to MIN, which read as unsigned is exactly |MIN|.
    assign abs_a    = div_if.data_operandA[WIDTH-1] ? -div_if.data_operandA : div_if.data_operandA;
    assign abs_b    = div_if.data_operandB[WIDTH-1] ? -div_if.data_operandB : div_if.data_operandB;

    div_seq_32_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q[WIDTH-1:0]),
        .dvd_bit_i (dvd_q[WIDTH-1]),
        .divisor_i (absb_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= DIV_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (accept) state_d = (b_zero || overflow) ? DIV_DONE : DIV_RUN;
            DIV_RUN:  if (count_q == '0) state_d = DIV_FIX;
            DIV_FIX:  state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    // Datapath and output next values per state
    always_comb begin
        count_d     = count_q;
        absb_d      = absb_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        exc_pend_d  = exc_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        exception_d = exception_q;
        rdy_d       = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            DIV_IDLE: begin
                if (accept) begin
                    busy_d = 1'b1;
                    if (b_zero) begin
                        dvd_d      = '0;
                        rem_d      = {1'b0, div_if.data_operandA};
                        exc_pend_d = 1'b1;
                    end else if (overflow) begin
                        dvd_d      = MIN_VAL;
                        rem_d      = '0;
                        exc_pend_d = 1'b1;
                    end else begin
                        dvd_d      = abs_a;
                        rem_d      = '0;
                        absb_d     = {1'b0, abs_b};
                        neg_quo_d  = div_if.data_operandA[WIDTH-1] ^ div_if.data_operandB[WIDTH-1];
                        neg_rem_d  = div_if.data_operandA[WIDTH-1];
                        exc_pend_d = 1'b0;
                        count_d    = CW'(WIDTH - 1);
                    end
                end else begin
                    // Closing the result cycle: busy falls one edge after resultRDY.
                    busy_d = 1'b0;
                end
            end
            DIV_RUN: begin
                rem_d   = step_rem;
                dvd_d   = {dvd_q[WIDTH-2:0], step_q};
                count_d = count_q - CW'(1);
            end
            DIV_FIX: begin
                dvd_d = neg_quo_q ? -dvd_q : dvd_q;
                rem_d = neg_rem_q ? -rem_q : rem_q;
            end
            DIV_DONE: begin
                quotient_d  = dvd_q;
                remainder_d = rem_q[WIDTH-1:0];
                exception_d = exc_pend_q;
                rdy_d       = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= '0;
            absb_q      <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            exc_pend_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            exception_q <= 1'b0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            count_q     <= count_d;
            absb_q      <= absb_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            exc_pend_q  <= exc_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            exception_q <= exception_d;
            rdy_q       <= rdy_d;
            busy_q      <= busy_d;
        end
    end

    assign div_if.data_quotient  = quotient_q;
    assign div_if.data_remainder = remainder_q;
    assign div_if.data_exception = exception_q;
    assign div_if.data_resultRDY = rdy_q;
    assign div_if.busy           = busy_q;

endmodule

// File: tb/tb_div_seq_32.sv
// Self-checking bench for div_seq_32: scoreboard of expected results, one task per scenario.
module tb_div_seq_32;
    import div_seq_32_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
        int          lat;
    } exp_t;

    logic clock;
    logic reset;
    int   checks_total;
    int   checks_passed;
    exp_t sb_q[$];

    div_seq_32_if #(.WIDTH(32)) bus ();

    div_seq_32 #(.WIDTH(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .div_if (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: SV signed division truncates toward zero; remainder takes dividend sign.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sa;
        int   sbv;
        e.a = a;
        e.b = b;
        if (b == 32'd0) begin
            e.q = 32'd0; e.r = a; e.exc = 1'b1; e.lat = 1;
        end else if (a == DIV_MIN && b == 32'hFFFF_FFFF) begin
            e.q = DIV_MIN; e.r = 32'd0; e.exc = 1'b1; e.lat = 1;
        end else begin
            sa  = a;
            sbv = b;
            e.q = sa / sbv;
            e.r = sa % sbv;
            e.exc = 1'b0;
            e.lat = 34;
        end
        return e;
    endfunction

    // Issue one start pulse; the posedge inside is the accept edge (cycle 0).
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit expect_result);
        @(negedge clock);
        bus.ctrl_div      = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_div = 1'b0;
        if (expect_result) sb_q.push_back(model(a, b));
    endtask

    // Wait for resultRDY, compare against the scoreboard head, check busy/pulse shape.
    // inject_cyc >= 0 drives a 9/3 start pulse during that cycle of the running op.
    // poke_done drives a start during the resultRDY cycle, which must be ignored.
    task automatic wait_result(input string name, input int inject_cyc, input bit poke_done);
        bit   seen;
        bit   busy_ok;
        int   lat;
        exp_t e;
        seen    = 1'b0;
        busy_ok = 1'b1;
        lat     = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (c == inject_cyc) begin
                bus.ctrl_div      = 1'b1;
                bus.data_operandA = 32'd9;
                bus.data_operandB = 32'd3;
            end
            if (c == inject_cyc + 1) bus.ctrl_div = 1'b0;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.data_resultRDY === 1'b1) begin
                seen = 1'b1;
                lat  = c;
                break;
            end
        end
        checks_total++;
        if (!seen) begin
            $display("FAIL %s timeout: resultRDY got never, want within 60 cycles", name);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        checks_passed++;
        if (sb_q.size() == 0) begin
            checks_total++;
            $display("FAIL %s scoreboard: got result, want none pending", name);
            return;
        end
        e = sb_q.pop_front();
        checks_total++;
        if (lat !== e.lat) $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
        else checks_passed++;
        checks_total++;
        if (bus.data_quotient !== e.q)
            $display("FAIL %s quotient (%h/%h): got %h want %h", name, e.a, e.b, bus.data_quotient, e.q);
        else checks_passed++;
        checks_total++;
        if (bus.data_remainder !== e.r)
            $display("FAIL %s remainder (%h/%h): got %h want %h", name, e.a, e.b, bus.data_remainder, e.r);
        else checks_passed++;
        checks_total++;
        if (bus.data_exception !== e.exc)
            $display("FAIL %s exception: got %b want %b", name, bus.data_exception, e.exc);
        else checks_passed++;
        checks_total++;
        if (!busy_ok) $display("FAIL %s busy: got low during op, want high cycles 0..%0d", name, lat);
        else checks_passed++;
        if (poke_done) begin
            bus.ctrl_div      = 1'b1;
            bus.data_operandA = 32'd77;
            bus.data_operandB = 32'd5;
            @(posedge clock);
            #1;
            bus.ctrl_div = 1'b0;
        end
        @(negedge clock);
        checks_total++;
        if (bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL %s after_rdy: got rdy=%b busy=%b want rdy=0 busy=0",
                     name, bus.data_resultRDY, bus.busy);
        else checks_passed++;
        $display("op %s: %h / %h -> q=%h r=%h exc=%b lat=%0d", name, e.a, e.b,
                 bus.data_quotient, bus.data_remainder, bus.data_exception, lat);
    endtask

    task automatic test_reset();
        reset             = 1'b1;
        bus.ctrl_div      = 1'b1;
        bus.data_operandA = 32'd5;
        bus.data_operandB = 32'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks_total++;
        if (bus.busy !== 1'b0 || bus.data_resultRDY !== 1'b0)
            $display("FAIL reset_ctrl: got busy=%b rdy=%b want 0 0", bus.busy, bus.data_resultRDY);
        else checks_passed++;
        checks_total++;
        if (bus.data_quotient !== 32'd0 || bus.data_remainder !== 32'd0 || bus.data_exception !== 1'b0)
            $display("FAIL reset_outputs: got q=%h r=%h exc=%b want 0 0 0",
                     bus.data_quotient, bus.data_remainder, bus.data_exception);
        else checks_passed++;
        bus.ctrl_div = 1'b0;
        reset        = 1'b0;
        @(negedge clock);
        checks_total++;
        if (bus.busy !== 1'b0) $display("FAIL reset_idle: got busy=%b want 0", bus.busy);
        else checks_passed++;
        $display("reset: busy=%b q=%h r=%h", bus.busy, bus.data_quotient, bus.data_remainder);
    endtask

    task automatic test_basic();
        start_op(32'd100, 32'd7, 1'b1);
        wait_result("basic_100_7", -1, 1'b0);
    endtask

    task automatic test_signs();
        start_op(32'hFFFF_FF9C, 32'd7, 1'b1);
        wait_result("neg_dividend", -1, 1'b0);
        start_op(32'd100, 32'hFFFF_FFF9, 1'b1);
        wait_result("neg_divisor", -1, 1'b0);
        start_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);
        wait_result("both_neg", -1, 1'b0);
    endtask

    task automatic test_exceptions();
        start_op(32'd5, 32'd0, 1'b1);
        wait_result("div_by_zero", -1, 1'b0);
        start_op(DIV_MIN, 32'hFFFF_FFFF, 1'b1);
        wait_result("overflow", -1, 1'b0);
    endtask

    task automatic test_boundary();
        start_op(DIV_MIN, 32'd1, 1'b1);
        wait_result("min_by_1", -1, 1'b0);
        start_op(DIV_MIN, 32'd2, 1'b1);
        wait_result("min_by_2", -1, 1'b0);
        start_op(32'd3, 32'd7, 1'b1);
        wait_result("small_dividend", -1, 1'b0);
        start_op(32'h7FFF_FFFF, DIV_MIN, 1'b1);
        wait_result("max_by_min", -1, 1'b0);
    endtask

    task automatic test_ignore_busy();
        start_op(32'd100, 32'd7, 1'b1);
        wait_result("ignore_mid_start", 4, 1'b0);
        start_op(32'd9, 32'd3, 1'b1);
        wait_result("after_busy_9_3", -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        start_op(32'd1000, 32'hFFFF_FFDF, 1'b1);
        wait_result("start_in_done_ignored", -1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom_range(1, 1000);
            if (i[0]) b = -b;
            start_op(a, b, 1'b1);
            wait_result("random", -1, 1'b0);
        end
        start_op(32'd1000, 32'hFFFF_FFDF, 1'b1);
        wait_result("nonzero_before_abort", -1, 1'b0);
    endtask

    task automatic test_reset_abort();
        bit rdy_seen;
        start_op(32'd100, 32'd7, 1'b0);
        for (int c = 0; c < 10; c++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks_total++;
        if (bus.busy !== 1'b0 || bus.data_resultRDY !== 1'b0)
            $display("FAIL abort_ctrl: got busy=%b rdy=%b want 0 0", bus.busy, bus.data_resultRDY);
        else checks_passed++;
        checks_total++;
        if (bus.data_quotient !== 32'd0 || bus.data_remainder !== 32'd0 || bus.data_exception !== 1'b0)
            $display("FAIL abort_outputs: got q=%h r=%h exc=%b want 0 0 0",
                     bus.data_quotient, bus.data_remainder, bus.data_exception);
        else checks_passed++;
        reset    = 1'b0;
        rdy_seen = 1'b0;
        for (int c = 12; c <= 40; c++) begin
            @(negedge clock);
            if (bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0) rdy_seen = 1'b1;
        end
        checks_total++;
        if (rdy_seen) $display("FAIL abort_quiet: got activity after reset, want none");
        else checks_passed++;
        $display("abort: busy=%b q=%h r=%h", bus.busy, bus.data_quotient, bus.data_remainder);
        start_op(32'd20, 32'd6, 1'b1);
        wait_result("after_abort_20_6", -1, 1'b0);
    endtask

    initial begin
        checks_total      = 0;
        checks_passed     = 0;
        reset             = 1'b1;
        bus.ctrl_div      = 1'b0;
        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        test_reset();
        test_basic();
        test_signs();
        test_exceptions();
        test_boundary();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        checks_total++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        else checks_passed++;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
